gmii_to_rgmii_tx: RTL

Transmit-direction converter for the Ethernet PHY path: accepts an 8-bit single-data-rate GMII byte stream in the `gmii_tx_clk` domain and drives a 4-bit double-data-rate RGMII transmit interface toward the PHY. It sits between the MAC TX path and the RGMII pins, and is the counterpart of the `rgmil2gmil` receive converter. An optional inter-frame-gap guard drops frames that start too soon after the previous transmitted frame, and counts transmitted and dropped frames.

---
 rtl/gmii_to_rgmii_tx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/gmii_to_rgmii_tx.sv
// GMII (8-bit SDR) to RGMII (4-bit DDR) transmit converter with an optional inter-frame-gap guard.
// Define GMII_TX_IFG_GUARD_EN to compile in the guard FSM and the drop counter.
module gmii_to_rgmii_tx #(
    parameter int IFG_MIN = 12,
    parameter int CNT_W   = 16
) (
    input  logic             gmii_tx_clk,
    input  logic             sys_rst_n,
    input  logic             gmii_tx_en,
    input  logic             gmii_tx_er,
    input  logic [7:0]       gmii_txd,
    output logic             rgmii_tx_clk,
    output logic [3:0]       rgmii_txd,
    output logic             rgmii_tx_ctl,
    output logic [CNT_W-1:0] tx_frame_cnt,
    output logic [CNT_W-1:0] tx_drop_cnt
);
    localparam int IFG_W = $clog2(IFG_MIN + 1);

    logic             r_s1_en;
    logic             r_s1_er;
    logic [7:0]       r_s1_d;
    logic [3:0]       r_d_rise;
    logic [3:0]       r_d_fall;
    logic             r_c_rise;
    logic             r_c_fall;
    logic [3:0]       r_q_rise;
    logic [3:0]       r_q_fall;
    logic             r_qc_rise;
    logic             r_qc_fall;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             w_fwd;
    logic             w_frame_end;

`ifdef GMII_TX_IFG_GUARD_EN
    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DROP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IFG_W-1:0] r_ifg_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             w_drop_start;

    always_ff @(posedge gmii_tx_clk) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Decision is taken on the raw inputs so the first byte of a frame is already gated.
    always_comb begin
        w_state_nxt  = r_state;
        w_fwd        = 1'b1;
        w_frame_end  = 1'b0;
        w_drop_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (gmii_tx_en) begin
                    if (r_ifg_cnt >= IFG_W'(IFG_MIN)) begin
                        w_state_nxt = S_FRAME;
                    end else begin
                        w_state_nxt  = S_DROP;
                        w_fwd        = 1'b0;
                        w_drop_start = 1'b1;
                    end
                end
            end
            S_FRAME: begin
                if (!gmii_tx_en) begin
                    w_state_nxt = S_IDLE;
                    w_frame_end = 1'b1;
                end
            end
            S_DROP: begin
                w_fwd = 1'b0;
                if (!gmii_tx_en) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Gap is measured from the last forwarded frame; dropped frames do not restart it.
    always_ff @(posedge gmii_tx_clk) begin
        if (!sys_rst_n)
            r_ifg_cnt <= IFG_W'(IFG_MIN);
        else if (w_frame_end)
            r_ifg_cnt <= IFG_W'(1);
        else if (r_state != S_FRAME && r_ifg_cnt < IFG_W'(IFG_MIN))
            r_ifg_cnt <= r_ifg_cnt + IFG_W'(1);
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (!sys_rst_n)        r_drop_cnt <= '0;
        else if (w_drop_start) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end

    assign tx_drop_cnt = r_drop_cnt;
`else
    logic r_prev_en;

    always_ff @(posedge gmii_tx_clk) begin
        if (!sys_rst_n) r_prev_en <= 1'b0;
        else            r_prev_en <= gmii_tx_en;
    end

    assign w_fwd       = 1'b1;
    assign w_frame_end = r_prev_en & ~gmii_tx_en;
    assign tx_drop_cnt = '0;
`endif

    always_ff @(posedge gmii_tx_clk) begin
        if (!sys_rst_n)       r_frame_cnt <= '0;
        else if (w_frame_end) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end

    assign tx_frame_cnt = r_frame_cnt;

    always_ff @(posedge gmii_tx_clk) begin
        if (!sys_rst_n) begin
            r_s1_en <= 1'b0;
            r_s1_er <= 1'b0;
            r_s1_d  <= 8'h00;
        end else begin
            r_s1_en <= gmii_tx_en & w_fwd;
            r_s1_er <= gmii_tx_er & w_fwd;
            r_s1_d  <= w_fwd ? gmii_txd : 8'h00;
        end
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (!sys_rst_n) begin
            r_d_rise <= 4'h0;
            r_d_fall <= 4'h0;
            r_c_rise <= 1'b0;
            r_c_fall <= 1'b0;
        end else begin
            r_d_rise <= r_s1_d[3:0];
            r_d_fall <= r_s1_d[7:4];
            r_c_rise <= r_s1_en;
            r_c_fall <= r_s1_en ^ r_s1_er;
        end
    end

    // SAME_EDGE ODDR: both halves captured on the rising edge, then muxed by the clock level.
    always_ff @(posedge gmii_tx_clk) begin
        if (!sys_rst_n) begin
            r_q_rise  <= 4'h0;
            r_q_fall  <= 4'h0;
            r_qc_rise <= 1'b0;
            r_qc_fall <= 1'b0;
        end else begin
            r_q_rise  <= r_d_rise;
            r_q_fall  <= r_d_fall;
            r_qc_rise <= r_c_rise;
            r_qc_fall <= r_c_fall;
        end
    end

    assign rgmii_tx_clk = gmii_tx_clk;
    assign rgmii_txd    = gmii_tx_clk ? r_q_rise  : r_q_fall;
    assign rgmii_tx_ctl = gmii_tx_clk ? r_qc_rise : r_qc_fall;

endmodule
